// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the main-memory port arbiter: FSM states,
// grant identifiers and default sizing.
package mem_port_arbiter_pkg;

    localparam int REG_SIZE    = 32;
    localparam int WIDTH       = 128;
    localparam int TIMEOUT_DEF = 255;
    localparam int TMO_CNT_W   = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RESP    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_IC  = 2'd0;
    localparam logic [1:0] GNT_DCR = 2'd1;
    localparam logic [1:0] GNT_DCW = 2'd2;

    function automatic logic is_d_side(input logic [1:0] gnt);
        return (gnt != GNT_IC);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: write-back beats fill on the D side, and a
// 1-bit round-robin pointer settles I-side versus D-side contention.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       ic_req,
    input  logic       dcr_req,
    input  logic       dcw_req,
    input  logic       last_d,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);

    logic [1:0] d_id_s;
    logic       d_req_s;

    // Winner selection; last_d=1 means D was served last, so I goes first.
    always_comb begin
        d_req_s   = dcr_req | dcw_req;
        d_id_s    = dcw_req ? GNT_DCW : GNT_DCR;
        gnt_valid = ic_req | d_req_s;
        if (ic_req && d_req_s) begin
            gnt_id = last_d ? GNT_IC : d_id_s;
        end else if (ic_req) begin
            gnt_id = GNT_IC;
        end else if (d_req_s) begin
            gnt_id = d_id_s;
        end else begin
            gnt_id = GNT_IC;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the asynchronous main-memory port between I-cache fill, D-cache fill
// and D-cache write-back using a four-state enable/ack handshake FSM.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = REG_SIZE,
    parameter int LINE_W  = WIDTH,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_read_req,
    input  logic [ADDR_W-1:0] ic_read_addr,
    output logic              ic_read_ack,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              dc_read_req,
    input  logic [ADDR_W-1:0] dc_read_addr,
    output logic              dc_read_ack,
    output logic [LINE_W-1:0] dc_read_data,
    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_write_ack,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_data_out,
    input  logic [LINE_W-1:0] mem_data_in,
    input  logic              mem_ack,
    output logic              mem_err
);

    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);
    localparam logic [TMO_CNT_W-1:0] TMO_MAX  = {TMO_CNT_W{1'b1}};

    arb_state_t            state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  last_d_q, last_d_d;
    logic                  mem_enable_q, mem_enable_d;
    logic                  mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]     mem_data_out_q, mem_data_out_d;
    logic [LINE_W-1:0]     ic_data_q, ic_data_d;
    logic [LINE_W-1:0]     dc_data_q, dc_data_d;
    logic                  ic_ack_q, ic_ack_d;
    logic                  dcr_ack_q, dcr_ack_d;
    logic                  dcw_ack_q, dcw_ack_d;
    logic                  mem_err_q, mem_err_d;
    logic [TMO_CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [1:0]            pick_id_s;
    logic                  pick_valid_s;

    arb_pick u_pick (
        .ic_req    (ic_read_req),
        .dcr_req   (dc_read_req),
        .dcw_req   (dc_write_req),
        .last_d    (last_d_q),
        .gnt_id    (pick_id_s),
        .gnt_valid (pick_valid_s)
    );

    // Next-state, grant capture, completion and timeout logic.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_d_d       = last_d_q;
        mem_enable_d   = mem_enable_q;
        mem_rw_d       = mem_rw_q;
        mem_addr_d     = mem_addr_q;
        mem_data_out_d = mem_data_out_q;
        ic_data_d      = ic_data_q;
        dc_data_d      = dc_data_q;
        ic_ack_d       = 1'b0;
        dcr_ack_d      = 1'b0;
        dcw_ack_d      = 1'b0;
        mem_err_d      = mem_err_q;
        tmo_cnt_d      = tmo_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_d      = ARB_ISSUE;
                    gnt_d        = pick_id_s;
                    last_d_d     = is_d_side(pick_id_s);
                    mem_enable_d = 1'b1;
                    case (pick_id_s)
                        GNT_DCW: begin
                            mem_rw_d       = 1'b1;
                            mem_addr_d     = dc_write_addr;
                            mem_data_out_d = dc_write_data;
                        end
                        GNT_DCR: begin
                            mem_rw_d   = 1'b0;
                            mem_addr_d = dc_read_addr;
                        end
                        default: begin
                            mem_rw_d   = 1'b0;
                            mem_addr_d = ic_read_addr;
                        end
                    endcase
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (mem_ack) begin
                    state_d      = ARB_RESP;
                    mem_enable_d = 1'b0;
                    tmo_cnt_d    = {TMO_CNT_W{1'b0}};
                    case (gnt_q)
                        GNT_DCW: dcw_ack_d = 1'b1;
                        GNT_DCR: begin
                            dcr_ack_d = 1'b1;
                            dc_data_d = mem_data_in;
                        end
                        default: begin
                            ic_ack_d  = 1'b1;
                            ic_data_d = mem_data_in;
                        end
                    endcase
                end else begin
                    // Timeout only flags the error; the access is still awaited.
                    if (tmo_cnt_q >= TMO_LAST) begin
                        mem_err_d = 1'b1;
                    end else begin
                        mem_err_d = mem_err_q;
                    end
                    if (tmo_cnt_q != TMO_MAX) begin
                        tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                    end else begin
                        tmo_cnt_d = tmo_cnt_q;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                if (!mem_ack) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_RELEASE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ARB_IDLE;
            gnt_q          <= GNT_IC;
            last_d_q       <= 1'b0;
            mem_enable_q   <= 1'b0;
            mem_rw_q       <= 1'b0;
            mem_addr_q     <= {ADDR_W{1'b0}};
            mem_data_out_q <= {LINE_W{1'b0}};
            ic_data_q      <= {LINE_W{1'b0}};
            dc_data_q      <= {LINE_W{1'b0}};
            ic_ack_q       <= 1'b0;
            dcr_ack_q      <= 1'b0;
            dcw_ack_q      <= 1'b0;
            mem_err_q      <= 1'b0;
            tmo_cnt_q      <= {TMO_CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            last_d_q       <= last_d_d;
            mem_enable_q   <= mem_enable_d;
            mem_rw_q       <= mem_rw_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            ic_data_q      <= ic_data_d;
            dc_data_q      <= dc_data_d;
            ic_ack_q       <= ic_ack_d;
            dcr_ack_q      <= dcr_ack_d;
            dcw_ack_q      <= dcw_ack_d;
            mem_err_q      <= mem_err_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    assign ic_read_ack  = ic_ack_q;
    assign ic_read_data = ic_data_q;
    assign dc_read_ack  = dcr_ack_q;
    assign dc_read_data = dc_data_q;
    assign dc_write_ack = dcw_ack_q;
    assign mem_enable   = mem_enable_q;
    assign mem_rw       = mem_rw_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_out = mem_data_out_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural memory with programmable
// ack delay/linger and requesters that drop (and optionally re-raise) on ack.
module tb_mem_port_arbiter;

    localparam logic [127:0] RD_TAG = {32'hDEADBEEF, 64'h0123_4567_89AB_CDEF, 32'h0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ic_read_req, dc_read_req, dc_write_req;
    logic [31:0]  ic_read_addr, dc_read_addr, dc_write_addr;
    logic [127:0] dc_write_data, mem_data_in;
    logic         ic_read_ack, dc_read_ack, dc_write_ack;
    logic [127:0] ic_read_data, dc_read_data, mem_data_out;
    logic         mem_enable, mem_rw, mem_ack, mem_err;
    logic [31:0]  mem_addr;

    int n_tests = 0;
    int n_fail  = 0;

    int mem_delay, mem_linger, mem_cnt, linger_cnt, viol, ack_wide;
    bit ic_auto, dcr_auto, dcw_auto, ic_rearm, dcr_rearm, dcw_rearm;
    logic         en_prev;
    logic [2:0]   ack_prev;
    logic [31:0]  cur_addr;
    logic         cur_rw;
    logic [127:0] cur_data;
    logic [1:0]   gnt_log[$];
    logic [31:0]  acc_addr[$];
    logic         acc_rw[$];
    logic [127:0] acc_data[$];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk          (clk),
        .reset        (rst_n),
        .ic_read_req  (ic_read_req),
        .ic_read_addr (ic_read_addr),
        .ic_read_ack  (ic_read_ack),
        .ic_read_data (ic_read_data),
        .dc_read_req  (dc_read_req),
        .dc_read_addr (dc_read_addr),
        .dc_read_ack  (dc_read_ack),
        .dc_read_data (dc_read_data),
        .dc_write_req (dc_write_req),
        .dc_write_addr(dc_write_addr),
        .dc_write_data(dc_write_data),
        .dc_write_ack (dc_write_ack),
        .mem_enable   (mem_enable),
        .mem_rw       (mem_rw),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_ack      (mem_ack),
        .mem_err      (mem_err)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample DUT just after the edge, then advance memory and requester models.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_enable && !en_prev) begin
            acc_addr.push_back(mem_addr);
            acc_rw.push_back(mem_rw);
            acc_data.push_back(mem_data_out);
            cur_addr = mem_addr;
            cur_rw   = mem_rw;
            cur_data = mem_data_out;
            if (mem_ack) viol++;
        end else if (mem_enable && en_prev) begin
            if (mem_addr !== cur_addr || mem_rw !== cur_rw || mem_data_out !== cur_data) viol++;
        end
        en_prev = mem_enable;
        if ((ic_read_ack && ack_prev[0]) || (dc_read_ack && ack_prev[1]) || (dc_write_ack && ack_prev[2]))
            ack_wide++;
        ack_prev = {dc_write_ack, dc_read_ack, ic_read_ack};
        if (mem_enable) begin
            linger_cnt = 0;
            if (mem_cnt >= mem_delay) mem_ack = 1'b1;
            else mem_cnt++;
        end else begin
            mem_cnt = 0;
            if (mem_ack && linger_cnt < mem_linger) linger_cnt++;
            else begin
                mem_ack    = 1'b0;
                linger_cnt = 0;
            end
        end
        mem_data_in = RD_TAG | {96'h0, mem_addr};
        if (ic_read_ack) begin
            gnt_log.push_back(2'd0); ic_read_req = 1'b0; ic_rearm = ic_auto;
        end else if (ic_rearm) begin
            ic_read_req = 1'b1; ic_rearm = 1'b0;
        end
        if (dc_read_ack) begin
            gnt_log.push_back(2'd1); dc_read_req = 1'b0; dcr_rearm = dcr_auto;
        end else if (dcr_rearm) begin
            dc_read_req = 1'b1; dcr_rearm = 1'b0;
        end
        if (dc_write_ack) begin
            gnt_log.push_back(2'd2); dc_write_req = 1'b0; dcw_rearm = dcw_auto;
        end else if (dcw_rearm) begin
            dc_write_req = 1'b1; dcw_rearm = 1'b0;
        end
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        acc_addr.delete();
        acc_rw.delete();
        acc_data.delete();
        viol     = 0;
        ack_wide = 0;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k = 0;
        while (gnt_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq("grant_count", 128'(gnt_log.size()), 128'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0;
        ic_auto = 1'b0; dcr_auto = 1'b0; dcw_auto = 1'b0;
        ic_rearm = 1'b0; dcr_rearm = 1'b0; dcw_rearm = 1'b0;
        mem_ack = 1'b0; mem_cnt = 0; linger_cnt = 0; mem_delay = 0; mem_linger = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        en_prev  = 1'b0;
        ack_prev = 3'b000;
        clear_logs();
    endtask

    initial begin
        int k;
        int en_ticks;
        int err_at;
        logic [1:0] rr_exp[6];
        rst_n = 1'b0;
        ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0;
        ic_read_addr = 32'h0; dc_read_addr = 32'h0; dc_write_addr = 32'h0;
        dc_write_data = 128'h0; mem_data_in = 128'h0; mem_ack = 1'b0;
        mem_delay = 0; mem_linger = 0; mem_cnt = 0; linger_cnt = 0;
        ic_auto = 1'b0; dcr_auto = 1'b0; dcw_auto = 1'b0;
        ic_rearm = 1'b0; dcr_rearm = 1'b0; dcw_rearm = 1'b0;
        en_prev = 1'b0; ack_prev = 3'b000;
        cur_addr = 32'h0; cur_rw = 1'b0; cur_data = 128'h0;
        clear_logs();

        // Reset state.
        #12;
        check_eq("rst_mem_enable", 128'(mem_enable), 128'd0);
        check_eq("rst_mem_rw", 128'(mem_rw), 128'd0);
        check_eq("rst_mem_addr", 128'(mem_addr), 128'd0);
        check_eq("rst_acks", 128'({ic_read_ack, dc_read_ack, dc_write_ack}), 128'd0);
        check_eq("rst_mem_err", 128'(mem_err), 128'd0);
        check_eq("rst_ic_data", ic_read_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single I fill, memory acks two cycles after enable.
        mem_delay = 2;
        ic_read_addr = 32'h100;
        ic_read_req  = 1'b1;
        wait_grants(1, 40);
        tick(); tick();
        check_eq("i_fill_accesses", 128'(acc_addr.size()), 128'd1);
        check_eq("i_fill_rw", 128'(acc_rw[0]), 128'd0);
        check_eq("i_fill_addr", 128'(acc_addr[0]), 128'h100);
        check_eq("i_fill_data", ic_read_data, RD_TAG | 128'h100);
        check_eq("i_fill_ack_width", 128'(ack_wide), 128'd0);
        check_eq("i_fill_ack_low", 128'(ic_read_ack), 128'd0);
        repeat (5) tick();
        check_eq("i_fill_data_held", ic_read_data, RD_TAG | 128'h100);

        // Write-back and refill raised together: write-back first.
        clear_logs();
        dc_write_addr = 32'h200;
        dc_write_data = 128'hA5A5_0001_5A5A_0002_C3C3_0003_3C3C_0004;
        dc_read_addr  = 32'h300;
        dc_write_req  = 1'b1;
        dc_read_req   = 1'b1;
        wait_grants(2, 60);
        tick(); tick();
        check_eq("wb_first_gnt", 128'(gnt_log[0]), 128'd2);
        check_eq("wb_second_gnt", 128'(gnt_log[1]), 128'd1);
        check_eq("wb_rw", 128'(acc_rw[0]), 128'd1);
        check_eq("wb_addr", 128'(acc_addr[0]), 128'h200);
        check_eq("wb_data", acc_data[0], 128'hA5A5_0001_5A5A_0002_C3C3_0003_3C3C_0004);
        check_eq("fill_rw", 128'(acc_rw[1]), 128'd0);
        check_eq("fill_addr", 128'(acc_addr[1]), 128'h300);
        check_eq("fill_data", dc_read_data, RD_TAG | 128'h300);
        check_eq("ic_data_kept", ic_read_data, RD_TAG | 128'h100);
        check_eq("addr_stable", 128'(viol), 128'd0);

        // Round-robin with all three requesting from last_d=0.
        do_reset();
        rr_exp = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        ic_auto = 1'b1; dcr_auto = 1'b1;
        ic_read_req = 1'b1; dc_read_req = 1'b1; dc_write_req = 1'b1;
        wait_grants(6, 200);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("rr_gnt%0d", i), 128'(gnt_log[i]), 128'(rr_exp[i]));
        end
        ic_auto = 1'b0; dcr_auto = 1'b0; ic_rearm = 1'b0; dcr_rearm = 1'b0;
        repeat (30) tick();

        // Slow memory: error after 255 full ISSUE cycles, access still completes.
        do_reset();
        mem_delay = 300;
        ic_read_addr = 32'h440;
        ic_read_req  = 1'b1;
        en_ticks = 0;
        err_at   = 0;
        k = 0;
        while (gnt_log.size() < 1 && k < 400) begin
            tick();
            k++;
            if (mem_enable) en_ticks++;
            if (mem_err && err_at == 0) err_at = en_ticks;
        end
        check_eq("slow_completes", 128'(gnt_log.size()), 128'd1);
        check_eq("slow_err_cycle", 128'(err_at), 128'd256);
        check_eq("slow_data", ic_read_data, RD_TAG | 128'h440);
        repeat (20) tick();
        check_eq("err_sticky", 128'(mem_err), 128'd1);
        do_reset();
        check_eq("err_cleared", 128'(mem_err), 128'd0);

        // Asynchronous reset in the middle of an access.
        mem_delay = 50;
        ic_read_req = 1'b1;
        repeat (3) tick();
        check_eq("mid_enable_high", 128'(mem_enable), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_enable_low", 128'(mem_enable), 128'd0);
        check_eq("async_addr_zero", 128'(mem_addr), 128'd0);
        check_eq("async_outputs_zero", 128'({mem_rw, mem_err, ic_read_ack, dc_read_ack, dc_write_ack}), 128'd0);
        ic_read_req = 1'b0; mem_ack = 1'b0; mem_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("idle_after_reset", 128'(mem_enable), 128'd0);

        // Zero-wait memory: grant edge then completion edge, ack in the third cycle.
        do_reset();
        ic_read_addr = 32'h80;
        ic_read_req  = 1'b1;
        k = 0;
        while (gnt_log.size() < 1 && k < 10) begin
            tick();
            k++;
        end
        check_eq("zero_wait_edges_to_ack", 128'(k), 128'd2);
        // Memory keeps ack high after enable drops: RELEASE must hold off the next grant.
        mem_linger = 4;
        ic_auto = 1'b1;
        ic_read_req = 1'b1;
        wait_grants(4, 80);
        check_eq("release_waits_ack_low", 128'(viol), 128'd0);
        ic_auto = 1'b0; ic_rearm = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single asynchronous main-memory port between three cache-side requesters: I-cache line fill, D-cache line fill and D-cache line write-back. Sits between the two `cache` instances and `memory_async` in `cpu`. Runs a 4-phase enable/ack handshake toward memory and a req/ack-pulse handshake toward each requester. Returns fill data on a per-requester held bus.

## Interface
- `ADDR_W`, default 32: memory byte-address width (`REG_SIZE`).
- `LINE_W`, default 128: transfer width, one cache line (`WIDTH`).
- `TIMEOUT`, default 255: maximum cycles in ISSUE before `mem_err` is raised.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `ic_read_req` in 1: I-cache fill request, level.
- `ic_read_addr` in ADDR_W: I-cache fill address.
- `ic_read_ack` out 1: one-cycle pulse, fill complete.
- `ic_read_data` out LINE_W: I-cache fill line.
- `dc_read_req` in 1: D-cache fill request, level.
- `dc_read_addr` in ADDR_W: D-cache fill address.
- `dc_read_ack` out 1: one-cycle pulse, fill complete.
- `dc_read_data` out LINE_W: D-cache fill line.
- `dc_write_req` in 1: D-cache write-back request, level.
- `dc_write_addr` in ADDR_W: D-cache write-back address.
- `dc_write_data` in LINE_W: D-cache write-back line.
- `dc_write_ack` out 1: one-cycle pulse, write-back complete.
- `mem_enable` out 1: memory request, held through the access.
- `mem_rw` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: memory address.
- `mem_data_out` out LINE_W: write data to memory.
- `mem_data_in` in LINE_W: read data from memory.
- `mem_ack` in 1: memory completion, level.
- `mem_err` out 1: sticky, set on timeout.

## Operation
- States:
  - IDLE: pick the winner among asserted requests.
  - ISSUE: `mem_enable`=1, address, rw and data registered and stable; wait for `mem_ack`=1.
  - RESP: capture read data; pulse the winner's ack for one cycle; `mem_enable`=0.
  - RELEASE: wait for `mem_ack`=0, then go to IDLE.
- Priority within the D side: `dc_write` beats `dc_read`. The dirty victim is written back before the refill of the same set.
- I side vs D side: round-robin on a 1-bit `last_d` pointer. After a D grant, I wins the next contention; after an I grant, D wins. With no contention, the only requester wins.
- Read data: `mem_data_in` is captured in RESP into the winner's `*_read_data` register. The register holds until that requester's next completion.
- Requester rule: `*_req` stays high until its ack and drops the cycle after. No grant can occur during RELEASE, so a stale req is never re-granted.
- `mem_addr`, `mem_rw` and `mem_data_out` are registered at grant and do not change while `mem_enable`=1.
- Timeout: a counter (8 bits) runs in ISSUE.
  - Reaching `TIMEOUT` sets `mem_err`.
  - The access is still waited for; there is no abort.
  - The counter clears on leaving ISSUE.
- Reset (`reset`=0, asynchronous, any state):
  - state goes to IDLE; `mem_enable`, `mem_rw` and all acks go to 0; `mem_err` goes to 0; `last_d` goes to 0;
  - address and data registers go to 0;
  - an in-flight access is abandoned. Requesters are also reset, so no ack is owed.

## Timing
- Grant: a request seen in IDLE at edge N gives `mem_enable`=1 from edge N+1.
- Ack: `mem_ack` sampled high at edge M gives the requester's ack high for cycle M+1 to M+2, with data valid in the same cycle. `mem_enable` falls at M+1.
- Minimum total latency, req to ack: 3 cycles with a zero-wait memory. Back-to-back grants are separated by at least one RELEASE cycle plus IDLE.
- `mem_ack` already high on entry to ISSUE: treated as completion on the first ISSUE cycle.
- All three requests rising together, `last_d`=0: order of service is `dc_write`, `ic_read`, `dc_read`.
- Request dropped before ack: protocol violation, not supported. The access completes and the ack is still pulsed.

## Structure
- Shared package or defines:
  - state encoding `ARB_IDLE`, `ARB_ISSUE`, `ARB_RESP`, `ARB_RELEASE`;
  - grant ID constants `GNT_IC`, `GNT_DCR`, `GNT_DCW` (2 bits);
  - `TIMEOUT` default;
  - `REG_SIZE` and `WIDTH` reused from `define.v`.
- One sub-module, `arb_pick`: combinational winner selection from the three reqs and `last_d`. Outputs the grant ID and a valid bit.
- Everything else is in the top FSM.

## Test plan
- Single I fill: `ic_read_req`=1, `ic_read_addr`=0x100, memory acks 2 cycles after enable with data 0xDEADBEEF_...
  - `mem_rw`=0, `mem_addr`=0x100;
  - `ic_read_ack` pulse of exactly 1 cycle;
  - `ic_read_data` = memory data and held afterwards.
- Write-back before fill: `dc_write_req` and `dc_read_req` raised in the same cycle, addresses 0x200 and 0x300 → first access `mem_rw`=1 at 0x200 with `mem_data_out`=`dc_write_data`, then `mem_rw`=0 at 0x300.
- Round-robin: all three reqs held, requesters re-raising after ack → grant sequence DCW, IC, DCR, IC, …; I is never starved.
- Slow ack: memory withholds `mem_ack` for 300 cycles → `mem_err` rises at cycle 255 of ISSUE; the access still completes; `mem_err` stays set until reset.
- Reset mid-access: assert `reset`=0 during ISSUE → `mem_enable` drops with no clock edge; all outputs are 0. After release, with no reqs, state stays IDLE.
- Zero-wait memory: `mem_ack` tied high while `mem_enable`=1 → 3-cycle latency. RELEASE waits for `mem_ack` to fall before the next grant.
